aes_key_word_engine: RTL and testbench

//   Execute-stage consumer of the ID/EX AES fields (enable_AES, AES_W, key_size, re_adder_32, w2, plus1).

---
 rtl/aes_key_word_engine.sv | 147 ++++++++++++++
 tb/tb_aes_key_word_engine.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_word_engine.sv
// AES key-expansion word engine: produces one schedule word w[i] per command,
// running SubWord one byte per cycle through an external combinational S-box.
module aes_key_word_engine #(
  parameter logic [7:0] RCON_INIT = 8'h01,
  parameter int         IDX_W     = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             enable_aes,
  input  logic             aes_w,
  input  logic [1:0]       key_size,
  input  logic             plus1,
  input  logic [31:0]      w_prev,
  input  logic [31:0]      w_nk,
  output logic [7:0]       sbox_addr,
  input  logic [7:0]       sbox_data,
  output logic             busy,
  output logic             word_valid,
  output logic [31:0]      word_out,
  output logic [IDX_W-1:0] word_idx,
  output logic [7:0]       rcon_out
);

  typedef enum logic {IDLE = 1'b0, SUB = 1'b1} state_t;

  state_t           state, state_next;
  logic [1:0]       byte_cnt;
  logic [31:0]      src;
  logic [23:0]      temp;
  logic [31:0]      wnk_hold;
  logic             plus1_hold;
  logic [3:0]       nk;
  logic [2:0]       pos;

  logic             accept, is_init, is_word, need_sub, sub_go, pass_go, sub_done, advance;
  logic [3:0]       nk_sel;
  logic [IDX_W-1:0] last_idx, idx_adv;
  logic [2:0]       pos_adv;
  logic [7:0]       rcon_adv, rcon_xt;
  logic [31:0]      rcon_mask;

  always_comb begin
    case (key_size)
      2'b01:   nk_sel = 4'd6;
      2'b10:   nk_sel = 4'd8;
      default: nk_sel = 4'd4;
    endcase
  end

  assign accept    = (state == IDLE) && start && enable_aes;
  assign is_init   = accept && !aes_w;
  assign is_word   = accept && aes_w;
  assign need_sub  = (pos == 3'd0) || ((nk == 4'd8) && (pos == 3'd4));
  assign sub_go    = is_word && need_sub;
  assign pass_go   = is_word && !need_sub;
  assign sub_done  = (state == SUB) && start && (byte_cnt == 2'd3);
  assign advance   = (pass_go && plus1) || (sub_done && plus1_hold);
  assign rcon_mask = (pos == 3'd0) ? {rcon_out, 24'h000000} : 32'h0;
  assign rcon_xt   = {rcon_out[6:0], 1'b0} ^ (rcon_out[7] ? 8'h1b : 8'h00);
  // Last index of the schedule is 4*(Nr+1)-1 with Nr = Nk+6, i.e. 4*Nk+27.
  assign last_idx  = IDX_W'({nk, 2'b00}) + IDX_W'(27);

  always_comb begin
    idx_adv  = word_idx + IDX_W'(1);
    pos_adv  = ({1'b0, pos} == nk - 4'd1) ? 3'd0 : pos + 3'd1;
    rcon_adv = (pos == 3'd0) ? rcon_xt : rcon_out;
    if (word_idx == last_idx) begin
      idx_adv  = IDX_W'(nk);
      pos_adv  = 3'd0;
      rcon_adv = RCON_INIT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sub_go) state_next = SUB;
      SUB:     if (!start || (byte_cnt == 2'd3)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == SUB);
    sbox_addr = 8'h00;
    if (state == SUB) sbox_addr = src[{byte_cnt, 3'b000} +: 8];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt   <= 2'd0;
      src        <= 32'h0;
      temp       <= 24'h0;
      wnk_hold   <= 32'h0;
      plus1_hold <= 1'b0;
      nk         <= 4'd4;
      pos        <= 3'd0;
      word_idx   <= '0;
      rcon_out   <= RCON_INIT;
      word_out   <= 32'h0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (is_init) begin
        nk       <= nk_sel;
        word_idx <= IDX_W'(nk_sel);
        pos      <= 3'd0;
        rcon_out <= RCON_INIT;
      end
      if (pass_go) begin
        word_out   <= w_nk ^ w_prev;
        word_valid <= 1'b1;
      end
      if (sub_go) begin
        src        <= (pos == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
        wnk_hold   <= w_nk;
        plus1_hold <= plus1;
        byte_cnt   <= 2'd0;
      end
      // A dropped start leaves the SUB state without touching word_out or the counters.
      if ((state == SUB) && start) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0:    temp[7:0]   <= sbox_data;
          2'd1:    temp[15:8]  <= sbox_data;
          2'd2:    temp[23:16] <= sbox_data;
          default: begin
            word_out   <= wnk_hold ^ {sbox_data, temp} ^ rcon_mask;
            word_valid <= 1'b1;
          end
        endcase
      end
      if (advance) begin
        word_idx <= idx_adv;
        pos      <= pos_adv;
        rcon_out <= rcon_adv;
      end
    end
  end

endmodule

// File: tb/tb_aes_key_word_engine.sv
// Bench for aes_key_word_engine: FIPS-197 schedules plus randomized commands,
// checked every cycle against a key-schedule model derived from the word index.
module tb_aes_key_word_engine;
  logic        clk = 1'b0;
  logic        reset, start, enable_aes, aes_w, plus1;
  logic [1:0]  key_size;
  logic [31:0] w_prev, w_nk;
  logic [7:0]  sbox_addr, sbox_data;
  logic        busy, word_valid;
  logic [31:0] word_out;
  logic [5:0]  word_idx;
  logic [7:0]  rcon_out;

  aes_key_word_engine dut (
    .clk(clk), .reset(reset), .start(start), .enable_aes(enable_aes), .aes_w(aes_w),
    .key_size(key_size), .plus1(plus1), .w_prev(w_prev), .w_nk(w_nk),
    .sbox_addr(sbox_addr), .sbox_data(sbox_data), .busy(busy), .word_valid(word_valid),
    .word_out(word_out), .word_idx(word_idx), .rcon_out(rcon_out)
  );

  always #5 clk = ~clk;

  logic [7:0]  sb [256];
  assign sbox_data = sb[sbox_addr];

  int          errors = 0;
  int          checks = 0;
  int          idx_m = 0;
  int          nk_m = 4;
  bit          chk_on = 1'b0;
  bit          exp_busy = 1'b0;
  bit          exp_valid = 1'b0;
  logic [31:0] exp_word = 32'h0;
  logic [31:0] last_exp;
  logic [31:0] ks [60];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [7:0] rc(input int j);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 1; k < j; k++) r = xt(r);
    return r;
  endfunction

  // Rcon register value while the next word to compute is w[i].
  function automatic logic [7:0] rcon_of(input int i, input int nk);
    return (i % nk == 0) ? rc(i / nk) : rc(i / nk + 1);
  endfunction

  function automatic logic [31:0] model_word(input int i, input int nk,
                                             input logic [31:0] wp, input logic [31:0] wn);
    if (i % nk == 0)
      return wn ^ sub_word({wp[23:0], wp[31:24]}) ^ {rc(i / nk), 24'h000000};
    else if (nk > 6 && i % nk == 4)
      return wn ^ sub_word(wp);
    else
      return wn ^ wp;
  endfunction

  function automatic bit sub_now();
    return (idx_m % nk_m == 0) || (nk_m == 8 && idx_m % nk_m == 4);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("busy", 32'(busy), 32'(exp_busy));
      check("word_valid", 32'(word_valid), 32'(exp_valid));
      check("word_idx", 32'(word_idx), 32'(idx_m));
      check("rcon_out", 32'(rcon_out), 32'(rcon_of(idx_m, nk_m)));
      if (exp_valid) check("word_out", word_out, exp_word);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init(input logic [1:0] ks_in);
    enable_aes = 1'b1; aes_w = 1'b0; key_size = ks_in;
    tick();
    enable_aes = 1'b0;
    nk_m = (ks_in == 2'b01) ? 6 : (ks_in == 2'b10) ? 8 : 4;
    idx_m = nk_m;
    exp_valid = 1'b0; exp_busy = 1'b0;
    $display("init key_size=%b nk=%0d", ks_in, nk_m);
  endtask

  task automatic word_cmd(input logic [31:0] wp, input logic [31:0] wn, input bit p1, input bit poke);
    bit sub;
    sub = sub_now();
    last_exp = model_word(idx_m, nk_m, wp, wn);
    enable_aes = 1'b1; aes_w = 1'b1; w_prev = wp; w_nk = wn; plus1 = p1;
    tick();
    enable_aes = 1'b0; w_prev = $urandom; w_nk = $urandom; plus1 = 1'($urandom);
    if (sub) begin
      exp_busy = 1'b1; exp_valid = 1'b0;
      if (poke) begin
        enable_aes = 1'b1; aes_w = 1'($urandom); key_size = 2'($urandom);
      end
      repeat (3) tick();
      enable_aes = 1'b0;
      tick();
      exp_busy = 1'b0;
    end
    exp_valid = 1'b1; exp_word = last_exp;
    $display("word i=%0d nk=%0d sub=%0d plus1=%0d poke=%0d out=%h", idx_m, nk_m, sub, p1, poke, last_exp);
    if (p1) begin
      idx_m++;
      if (idx_m == 4 * (nk_m + 7)) idx_m = nk_m;
    end
  endtask

  task automatic abort_cmd(input logic [31:0] wp, input logic [31:0] wn, input bit p1, input int k);
    enable_aes = 1'b1; aes_w = 1'b1; w_prev = wp; w_nk = wn; plus1 = p1;
    tick();
    enable_aes = 1'b0;
    exp_busy = 1'b1; exp_valid = 1'b0;
    repeat (k) tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    exp_busy = 1'b0;
    $display("abort i=%0d after %0d bytes", idx_m, k);
  endtask

  task automatic flush_cmd();
    start = 1'b0; enable_aes = 1'b1; aes_w = 1'($urandom); key_size = 2'($urandom);
    w_prev = $urandom; w_nk = $urandom; plus1 = 1'b1;
    tick();
    start = 1'b1; enable_aes = 1'b0;
    exp_valid = 1'b0; exp_busy = 1'b0;
    $display("flushed command ignored i=%0d", idx_m);
  endtask

  task automatic idle();
    tick();
    exp_valid = 1'b0; exp_busy = 1'b0;
  endtask

  task automatic run_schedule(input logic [1:0] ks_in, input int abort_at, input int poke_at);
    int last;
    do_init(ks_in);
    last = 4 * (nk_m + 7);
    for (int i = nk_m; i < last; i++) begin
      if (i == abort_at) abort_cmd(ks[i-1], ks[i-nk_m], 1'b1, 2);
      word_cmd(ks[i-1], ks[i-nk_m], 1'b1, i == poke_at);
      ks[i] = last_exp;
      if (nk_m == 4 && i == 4) begin
        check("fips_w4", word_out, 32'ha0fafe17);
        check("rcon_after_w4", 32'(rcon_out), 32'h02);
        check("idx_after_w4", 32'(word_idx), 32'd5);
      end
      if (nk_m == 4 && i == 5)  check("fips_w5", word_out, 32'h88542cb1);
      if (nk_m == 4 && i == 39) check("rcon_at_w40", 32'(rcon_out), 32'h36);
      if (nk_m == 4 && i == 43) check("fips_w43", word_out, 32'hb6630ca6);
      if (nk_m == 6 && i == 6)  check("fips192_w6", word_out, 32'hfe0c91f7);
      if (nk_m == 8 && i == 8)  check("fips256_w8", word_out, 32'h9ba35411);
      if (nk_m == 8 && i == 12) check("fips256_w12", word_out, 32'ha8b09c1a);
    end
    check("idx_wrap", 32'(word_idx), 32'(nk_m));
    check("rcon_wrap", 32'(rcon_out), 32'h01);
  endtask

  initial begin
    int r;
    for (int x = 0; x < 256; x++) sb[x] = sbox_calc(8'(x));
    reset = 1'b1; start = 1'b1; enable_aes = 1'b0; aes_w = 1'b0; key_size = 2'b00;
    plus1 = 1'b0; w_prev = 32'h0; w_nk = 32'h0;
    #12;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_valid", 32'(word_valid), 32'h0);
    check("rst_word", word_out, 32'h0);
    check("rst_idx", 32'(word_idx), 32'h0);
    check("rst_rcon", 32'(rcon_out), 32'h01);
    check("rst_sbox_addr", 32'(sbox_addr), 32'h0);
    tick();
    reset = 1'b0;
    idx_m = 0; nk_m = 4; exp_busy = 1'b0; exp_valid = 1'b0;
    chk_on = 1'b1;
    idle();

    ks[0] = 32'h2b7e1516; ks[1] = 32'h28aed2a6; ks[2] = 32'habf71588; ks[3] = 32'h09cf4f3c;
    run_schedule(2'b00, -1, -1);
    idle();
    ks[0] = 32'h8e73b0f7; ks[1] = 32'hda0e6452; ks[2] = 32'hc810f32b;
    ks[3] = 32'h809079e5; ks[4] = 32'h62f8ead2; ks[5] = 32'h522c6b7b;
    run_schedule(2'b01, -1, 12);
    ks[0] = 32'h603deb10; ks[1] = 32'h15ca71be; ks[2] = 32'h2b73aef0; ks[3] = 32'h857d7781;
    ks[4] = 32'h1f352c07; ks[5] = 32'h3b6108d7; ks[6] = 32'h2d9810a3; ks[7] = 32'h0914dff4;
    run_schedule(2'b10, 8, 12);
    idle();

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 11);
      if (r == 0)
        do_init(2'($urandom));
      else if (r == 1)
        idle();
      else if (r == 2)
        flush_cmd();
      else if (r == 3 && sub_now())
        abort_cmd($urandom, $urandom, 1'($urandom), $urandom_range(0, 3));
      else
        word_cmd($urandom, $urandom, $urandom_range(0, 3) != 0, 1'($urandom));
    end
    idle();

    // Asynchronous reset in the middle of a SubWord sequence.
    do_init(2'b00);
    enable_aes = 1'b1; aes_w = 1'b1; w_prev = $urandom; w_nk = $urandom; plus1 = 1'b1;
    tick();
    enable_aes = 1'b0;
    exp_busy = 1'b1; exp_valid = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    idx_m = 0; nk_m = 4; exp_busy = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'h0);
    check("async_rst_valid", 32'(word_valid), 32'h0);
    check("async_rst_word", word_out, 32'h0);
    check("async_rst_idx", 32'(word_idx), 32'h0);
    check("async_rst_rcon", 32'(rcon_out), 32'h01);
    check("async_rst_sbox_addr", 32'(sbox_addr), 32'h0);
    tick();
    reset = 1'b0;
    idle();
    do_init(2'b10);
    for (int n = 0; n < 10; n++) word_cmd($urandom, $urandom, 1'b1, 1'b0);
    idle();
    idle();
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
